// File: rtl/pma_rx_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pma_rx_aligner
//  Purpose  : Serial-to-parallel receive aligner. Shifts in one bit per
//             bit-rate clock edge, searches for the K28.5 comma (either
//             running disparity), establishes a word boundary and declares
//             lock after LOCK_CNT consecutive aligned commas. Loss of lock
//             follows UNLOCK_CNT commas seen off the established boundary.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK_5G      in   1           bit-rate clock, one serial bit per edge
//    Rst_n       in   1           asynchronous active-low reset
//    RX_POS      in   1           serial data, first received bit = bit a
//    RxPolarity  in   1           1 = invert RX_POS before processing
//    Data_out    out  DATA_WIDTH  aligned word, earliest bit at bit 0
//    Data_valid  out  1           one-cycle pulse per new Data_out
//    Comma_det   out  1           newest 10-bit symbol of Data_out is a comma
//    Locked      out  1           aligner is in the LOCKED state
//    Realign     out  1           one-cycle pulse when the boundary moves
// ============================================================================
module pma_rx_aligner #(
  parameter int         DATA_WIDTH = 10,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 4,
  parameter logic [9:0] COMMA      = 10'h17C
) (
  input  logic                  CLK_5G,
  input  logic                  Rst_n,
  input  logic                  RX_POS,
  input  logic                  RxPolarity,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_valid,
  output logic                  Comma_det,
  output logic                  Locked,
  output logic                  Realign
);

  localparam int                PH_W       = $clog2(DATA_WIDTH);
  localparam logic [PH_W-1:0]   c_PH_LAST  = PH_W'(DATA_WIDTH - 1);
  localparam logic [PH_W-1:0]   c_PH_ONE   = PH_W'(1);
  localparam logic [3:0]        c_LOCK     = 4'(LOCK_CNT);
  localparam logic [3:0]        c_UNLOCK   = 4'(UNLOCK_CNT);
  localparam logic [3:0]        c_CNT_ONE  = 4'd1;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_sreg;
  logic [PH_W-1:0]         r_ph;
  logic [3:0]              r_cnt;
  logic [3:0]              r_miss;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_comma;
  logic                    r_locked;
  logic                    r_realign;

  logic                    w_bit;
  logic [9:0]              w_sym;
  logic                    w_comma_hit;
  logic                    w_boundary;

  // Polarity correction happens before anything else sees the bit.
  assign w_bit       = RX_POS ^ RxPolarity;
  // The newest 10 bits sit at the top of the shift register.
  assign w_sym       = r_sreg[DATA_WIDTH-1 -: 10];
  assign w_comma_hit = (w_sym == COMMA) || (w_sym == ~COMMA);
  assign w_boundary  = (r_ph == c_PH_LAST);

  always_ff @(posedge CLK_5G or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= ST_SEARCH;
      r_sreg    <= '0;
      r_ph      <= '0;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_comma   <= 1'b0;
      r_locked  <= 1'b0;
      r_realign <= 1'b0;
    end else begin
      // Free-running datapath; FSM branches below override as needed.
      r_sreg    <= {w_bit, r_sreg[DATA_WIDTH-1:1]};
      r_ph      <= w_boundary ? '0 : (r_ph + c_PH_ONE);
      r_valid   <= 1'b0;
      r_comma   <= 1'b0;
      r_realign <= 1'b0;

      case (r_state)
        ST_SEARCH: begin
          if (w_comma_hit) begin
            // Comma seen: this edge becomes the new word boundary, so the
            // phase restarts and the comma word itself is emitted.
            r_ph      <= '0;
            r_data    <= r_sreg;
            r_valid   <= 1'b1;
            r_comma   <= 1'b1;
            r_realign <= 1'b1;
            r_cnt     <= c_CNT_ONE;
            r_miss    <= '0;
            if (c_CNT_ONE >= c_LOCK) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= ST_CANDIDATE;
            end
          end
        end

        ST_CANDIDATE: begin
          if (w_boundary) begin
            // A comma that lands on the boundary counts as aligned.
            r_data  <= r_sreg;
            r_valid <= 1'b1;
            r_comma <= w_comma_hit;
            if (w_comma_hit) begin
              r_cnt <= r_cnt + c_CNT_ONE;
              if ((r_cnt + c_CNT_ONE) >= c_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end
          end else if (w_comma_hit) begin
            // Comma off the candidate boundary: restart the candidate there.
            r_ph      <= '0;
            r_data    <= r_sreg;
            r_valid   <= 1'b1;
            r_comma   <= 1'b1;
            r_realign <= 1'b1;
            r_cnt     <= c_CNT_ONE;
          end
        end

        ST_LOCKED: begin
          if (w_boundary) begin
            r_data  <= r_sreg;
            r_valid <= 1'b1;
            r_comma <= w_comma_hit;
            if (w_comma_hit) begin
              r_miss <= '0;
            end
          end else if (w_comma_hit) begin
            if ((r_miss + c_CNT_ONE) >= c_UNLOCK) begin
              // Drop lock but keep the current phase; the next comma seen
              // in SEARCH decides where the boundary goes.
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_miss   <= '0;
              r_cnt    <= '0;
            end else begin
              r_miss <= r_miss + c_CNT_ONE;
            end
          end
        end

        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
          r_cnt    <= '0;
          r_miss   <= '0;
        end
      endcase
    end
  end

  assign Data_out   = r_data;
  assign Data_valid = r_valid;
  assign Comma_det  = r_comma;
  assign Locked     = r_locked;
  assign Realign    = r_realign;

endmodule
`default_nettype wire

// File: tb/tb_pma_rx_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pma_rx_aligner
//  Purpose  : Scoreboard bench for pma_rx_aligner (10-bit and 20-bit widths).
//             Stimulus pushes hand-derived expected words into queues; a
//             monitor per instance pops and compares on every Data_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pma_rx_aligner;

  localparam logic [9:0] c_K_NEG = 10'h17C;
  localparam logic [9:0] c_K_POS = 10'h283;
  localparam logic [9:0] c_D215  = 10'h155;
  localparam logic [6:0] c_PRE   = 7'b1001101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rx    = 1'b0;
  logic        pol   = 1'b0;
  logic        rx20  = 1'b0;
  logic        pol20 = 1'b0;

  logic [9:0]  dout;
  logic        dv, cd, lk, ra;
  logic [19:0] dout20;
  logic        dv20, cd20, lk20, ra20;

  pma_rx_aligner #(.DATA_WIDTH(10), .LOCK_CNT(3), .UNLOCK_CNT(4), .COMMA(10'h17C)) u_dut (
    .CLK_5G(clk), .Rst_n(rst_n), .RX_POS(rx), .RxPolarity(pol),
    .Data_out(dout), .Data_valid(dv), .Comma_det(cd), .Locked(lk), .Realign(ra)
  );

  pma_rx_aligner #(.DATA_WIDTH(20), .LOCK_CNT(3), .UNLOCK_CNT(4), .COMMA(10'h17C)) u_dut20 (
    .CLK_5G(clk), .Rst_n(rst_n), .RX_POS(rx20), .RxPolarity(pol20),
    .Data_out(dout20), .Data_valid(dv20), .Comma_det(cd20), .Locked(lk20), .Realign(ra20)
  );

  typedef struct packed {
    logic [19:0] data;
    logic        comma;
    logic        locked;
    logic        realign;
  } exp_t;

  exp_t q10[$];
  exp_t q20[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last20  = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------- checks
  task automatic check_word(input string nm, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got data=%h comma=%0b locked=%0b realign=%0b, required data=%h comma=%0b locked=%0b realign=%0b",
               nm, act.data, act.comma, act.locked, act.realign,
               exp.data, exp.comma, exp.locked, exp.realign);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic check_drained(input string nm);
    check_val({nm, "_q10_left"}, q10.size(), 0);
    check_val({nm, "_q20_left"}, q20.size(), 0);
    q10.delete();
    q20.delete();
  endtask

  function automatic exp_t mk(input logic [19:0] d, input logic c, input logic l, input logic r);
    exp_t e;
    e.data    = d;
    e.comma   = c;
    e.locked  = l;
    e.realign = r;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitors
  initial begin : mon10
    exp_t e;
    forever begin
      @(negedge clk);
      if (ra && !dv) begin
        n_tests++; n_fail++;
        $display("FAIL dut10_realign_alone: got realign=1 valid=0, required realign only with valid");
      end
      if (dv) begin
        if (q10.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dut10_unexpected_word: got data=%h, required no word", dout);
        end else begin
          e = q10.pop_front();
          check_word("dut10_word", {10'b0, dout, cd, lk, ra}, e);
        end
      end
    end
  end

  initial begin : mon20
    exp_t e;
    forever begin
      @(negedge clk);
      if (ra20 && !dv20) begin
        n_tests++; n_fail++;
        $display("FAIL dut20_realign_alone: got realign=1 valid=0, required realign only with valid");
      end
      if (dv20) begin
        if (q20.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dut20_unexpected_word: got data=%h, required no word", dout20);
        end else begin
          e = q20.pop_front();
          check_word("dut20_word", {dout20, cd20, lk20, ra20}, e);
        end
        if (last20 >= 0) check_val("dut20_valid_spacing", cyc - last20, 20);
        last20 = cyc;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, required run to complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_bit(input logic b, input logic p);
    @(negedge clk);
    rx  = b;
    pol = p;
  endtask

  task automatic send_sym(input logic [9:0] s, input logic inv, input logic p);
    for (int i = 0; i < 10; i++) send_bit(s[i] ^ inv, p);
  endtask

  task automatic send_pre(input logic inv, input logic p);
    for (int i = 0; i < 7; i++) send_bit(c_PRE[i] ^ inv, p);
  endtask

  task automatic send_bit20(input logic b);
    @(negedge clk);
    rx20 = b;
  endtask

  task automatic send_sym20(input logic [9:0] s);
    for (int i = 0; i < 10; i++) send_bit20(s[i]);
  endtask

  // Idle level is chosen so the polarity-corrected stream is all zeros.
  task automatic do_reset(input logic p);
    @(negedge clk);
    rst_n = 1'b0;
    pol   = p;
    rx    = p;
    rx20  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain;
    repeat (4) @(negedge clk);
  endtask

  // Standard lock-up expectation: 17C/283 alternating, lock on the third.
  task automatic push_lock_seq(input int n);
    for (int i = 0; i < n; i++)
      q10.push_back(mk({10'b0, (i % 2 == 0) ? c_K_NEG : c_K_POS}, 1'b1, (i >= 2), (i == 0)));
  endtask

  initial begin : stim
    // Reset state
    do_reset(1'b0);
    #1;
    check_val("reset_data_out", int'(dout), 0);
    check_val("reset_valid",    int'(dv), 0);
    check_val("reset_comma",    int'(cd), 0);
    check_val("reset_locked",   int'(lk), 0);
    check_val("reset_realign",  int'(ra), 0);

    // Lock acquisition
    push_lock_seq(6);
    send_pre(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    drain;
    check_val("lock_locked_final", int'(lk), 1);
    check_drained("lock");

    // Polarity: inverted stream with RxPolarity=1, then flip polarity while locked
    do_reset(1'b1);
    push_lock_seq(4);
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b1, 1'b0));
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b1, 1'b0));
    send_pre(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b1, 1'b1);
    for (int i = 4; i < 6; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    drain;
    check_val("polarity_still_locked", int'(lk), 1);
    check_drained("polarity");

    // Slip: bit a of the sixth symbol is dropped while locked
    do_reset(1'b0);
    push_lock_seq(5);
    q10.push_back(mk(20'h141, 1'b0, 1'b1, 1'b0));
    q10.push_back(mk(20'h2BE, 1'b0, 1'b1, 1'b0));
    q10.push_back(mk(20'h141, 1'b0, 1'b1, 1'b0));
    q10.push_back(mk(20'h2BE, 1'b0, 1'b1, 1'b0));
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b0, 1'b1));
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b0, 1'b0));
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b1, 1'b0));
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b1, 1'b0));
    send_pre(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) send_bit(c_K_POS[i], 1'b0);
    for (int i = 6; i < 14; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    drain;
    check_val("slip_relocked", int'(lk), 1);
    check_drained("slip");

    // Mis-lock: three extra bits ahead of the third comma while cnt=2
    do_reset(1'b0);
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b0, 1'b1));
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b0, 1'b0));
    q10.push_back(mk(20'h3E5,          1'b0, 1'b0, 1'b0));
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b0, 1'b1));
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b0, 1'b0));
    q10.push_back(mk({10'b0, c_K_NEG}, 1'b1, 1'b1, 1'b0));
    q10.push_back(mk({10'b0, c_K_POS}, 1'b1, 1'b1, 1'b0));
    send_pre(1'b0, 1'b0);
    send_sym(c_K_NEG, 1'b0, 1'b0);
    send_sym(c_K_POS, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    for (int i = 2; i < 6; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    drain;
    check_drained("mislock");

    // Reset at ph=4 while locked, then full re-acquisition
    do_reset(1'b0);
    push_lock_seq(4);
    send_pre(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(c_K_NEG[i], 1'b0);
    check_val("pre_reset_locked", int'(lk), 1);
    check_drained("pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_data_out", int'(dout), 0);
    check_val("async_reset_locked",   int'(lk), 0);
    check_val("async_reset_valid",    int'(dv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_lock_seq(4);
    send_pre(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_sym((i % 2 == 0) ? c_K_NEG : c_K_POS, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    drain;
    check_drained("reacquire");

    // 20-bit width: D21.5 + K28.5 pairs
    do_reset(1'b0);
    q20.push_back(mk(20'h5F155, 1'b1, 1'b0, 1'b1));
    q20.push_back(mk(20'hA0D55, 1'b1, 1'b0, 1'b0));
    q20.push_back(mk(20'h5F155, 1'b1, 1'b1, 1'b0));
    q20.push_back(mk(20'hA0D55, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 7; i++) send_bit20(c_PRE[i]);
    for (int i = 0; i < 4; i++) begin
      send_sym20(c_D215);
      send_sym20((i % 2 == 0) ? c_K_NEG : c_K_POS);
    end
    send_bit20(1'b0); send_bit20(1'b0);
    drain;
    check_val("width20_locked", int'(lk20), 1);
    check_drained("width20");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pma_rx_aligner.md
PMA_RX_ALIGNER -- requirements
Module: pma_rx_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, meaning the parallel word width in bits; legal values are 10 and 20.
REQ-002 SHALL have parameter LOCK_CNT, default 3, meaning the number of consecutive aligned commas needed to declare lock (1..15).
REQ-003 SHALL have parameter UNLOCK_CNT, default 4, meaning the number of consecutive misaligned commas that forces loss of lock (1..15).
REQ-004 SHALL have parameter COMMA, default 10'h17C, meaning K28.5 RD- with bit a at bit 0; its bitwise complement 10'h283 SHALL also be accepted as a comma.
REQ-005 SHALL have port CLK_5G, input, 1 bit: the bit-rate clock and the only clock; one serial bit is consumed per rising edge.
REQ-006 SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port RX_POS, input, 1 bit: the sampled serial data; the first bit received is bit a (LSB).
REQ-008 SHALL have port RxPolarity, input, 1 bit: when 1, RX_POS is inverted before any other processing.
REQ-009 SHALL have port Data_out, output, DATA_WIDTH bits: the aligned parallel word, with the earliest-received bit at bit 0.
REQ-010 SHALL have port Data_valid, output, 1 bit: a 1-cycle pulse marking a new Data_out.
REQ-011 SHALL have port Comma_det, output, 1 bit: a 1-cycle pulse, coincident with Data_valid, when the newest 10-bit symbol of the emitted word is a comma.
REQ-012 SHALL have port Locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-013 SHALL have port Realign, output, 1 bit: a 1-cycle pulse whenever the word boundary is moved.

Function
REQ-014 SHALL shift the (polarity-corrected) bit into the MSB of a DATA_WIDTH shift register sreg on every edge.
REQ-015 SHALL compute comma_hit combinationally as 1 when sreg[DATA_WIDTH-1:DATA_WIDTH-10] equals COMMA or ~COMMA.
REQ-016 SHALL run a phase counter ph, 0..DATA_WIDTH-1, wrapping; an edge with ph==DATA_WIDTH-1 is a boundary edge.
REQ-017 SHALL, at a boundary edge in CANDIDATE or LOCKED, load Data_out with the pre-edge sreg and pulse Data_valid the following cycle; Comma_det SHALL pulse in that same cycle if comma_hit was 1.
REQ-018 SHALL use an FSM with states SEARCH, CANDIDATE and LOCKED; in SEARCH, Data_valid SHALL stay 0.
REQ-019 In SEARCH, an edge with comma_hit=1 SHALL: set ph to 0, emit the word (per REQ-017), pulse Realign, set cnt to 1, and move to CANDIDATE.
REQ-020 In CANDIDATE, a boundary comma SHALL increment cnt; when cnt reaches LOCK_CNT the FSM SHALL go to LOCKED, with Locked rising together with that word's Data_valid.
REQ-021 In CANDIDATE, a comma_hit on a non-boundary edge SHALL realign exactly as in REQ-019, staying in CANDIDATE with cnt set to 1.
REQ-022 In LOCKED, a non-boundary comma_hit SHALL increment miss, and a boundary comma SHALL clear miss.
REQ-023 In LOCKED, when miss reaches UNLOCK_CNT, the FSM SHALL go to SEARCH, deassert Locked, and keep the boundary unchanged with no Realign.
REQ-024 SHALL ignore non-comma words for all counters.
REQ-025 If a boundary edge and a comma_hit coincide, the comma SHALL be treated as aligned.
REQ-026 SHALL let RxPolarity change at any time, with effect from the next edge; no flush SHALL occur.
REQ-027 When LOCK_CNT=1, the first comma in SEARCH SHALL go directly to LOCKED.

Reset
REQ-028 Rst_n=0 SHALL immediately clear sreg, ph, cnt, miss, Data_out (all zeros), Data_valid, Comma_det, Locked and Realign, and put the FSM in SEARCH.
REQ-029 Reset asserted mid-word or while LOCKED SHALL discard the partial word; after release, alignment SHALL restart from SEARCH.

Verification
REQ-030 Lock: DATA_WIDTH=10, 7 random bits then K28.5 RD-/RD+ alternating -> Realign on first comma; Data_out 17C, 283, 17C...; Locked rises on the 3rd comma word.
REQ-031 Polarity: RxPolarity=1 with an inverted stream -> same Data_out sequence as REQ-030; toggling RxPolarity while locked -> words invert and no unlock occurs.
REQ-032 Slip: while locked, delete one bit -> 4 misaligned commas, then Locked=0, SEARCH, then re-lock at the new phase after 3 more commas.
REQ-033 Mis-lock: in CANDIDATE with cnt=2, inject a comma at offset 3 -> Realign pulses, cnt=1, and Locked is delayed by 2 more words.
REQ-034 Width: DATA_WIDTH=20, stream D21.5+K28.5 pairs -> Data_out[19:10]=17C/283 alternating and Data_valid every 20 cycles.
REQ-035 Reset: assert Rst_n low for 1 cycle at ph=4 while locked -> all outputs 0 asynchronously, then full re-acquisition.
